// File: rtl/vgaconsole_pkg.sv
// Shared constants, FSM state type and the glyph-row slicing helper for the console glyph path.
package vgaconsole_pkg;

    localparam int GLYPH_W   = 5;
    localparam int GLYPH_H   = 7;
    localparam int FONT_BITS = 35;
    localparam int CODE_MIN  = 32;
    localparam int CODE_MAX  = 127;
    localparam int COL_W     = 3;
    localparam int SCALE_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } glyph_state_t;

    // Row r lives in bitmap[5r+4:5r] with bit 5r as the leftmost pixel; rows past the glyph are blank.
    function automatic logic [GLYPH_W-1:0] row_slice(
        input logic [FONT_BITS-1:0] bitmap,
        input logic [2:0]           row
    );
        logic [GLYPH_W-1:0] s;
        s = '0;
        for (int r = 0; r < GLYPH_H; r++) begin
            if (row == 3'(r)) begin
                s = bitmap[r*GLYPH_W +: GLYPH_W];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/vgaconsole_pixel_counter.sv
// Column/scale counter pair walking one glyph cell; flags the strobe that finishes the cell.
// Latency: end_of_glyph is combinational on the final advance. Backpressure: advances only when told to.
module vgaconsole_pixel_counter
    import vgaconsole_pkg::*;
#(
    parameter int GAP_COLS = 1,
    parameter int SCALE_X  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic             end_of_glyph
);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(GLYPH_W + GAP_COLS - 1);
    localparam logic [SCALE_W-1:0] SCALE_LAST = SCALE_W'(SCALE_X - 1);

    logic [SCALE_W-1:0] scale;

    assign end_of_glyph = advance && (col == COL_LAST) && (scale == SCALE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            scale <= '0;
        end else if (clear) begin
            col   <= '0;
            scale <= '0;
        end else if (advance) begin
            if (scale == SCALE_LAST) begin
                scale <= '0;
                col   <= (col == COL_LAST) ? '0 : col + 1'b1;
            end else begin
                scale <= scale + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vgaconsole_glyph_shifter.sv
// Accepts character codes, slices the selected glyph row from the ROM and serializes it one pixel per pixel_en.
// Latency: first pixel on the pixel_en after the load. Backpressure: char_ready drops while hold is full mid-glyph.
module vgaconsole_glyph_shifter
    import vgaconsole_pkg::*;
#(
    parameter int GAP_COLS = 1,
    parameter int SCALE_X  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic [6:0]           char_code,
    input  logic [2:0]           row_sel,
    output logic [6:0]           rom_addr,
    input  logic [FONT_BITS-1:0] rom_data,
    input  logic                 pixel_en,
    output logic                 pixel_out,
    output logic                 busy,
    output logic                 underrun
);

    glyph_state_t state_q, state_d;

    logic [GLYPH_W-1:0] slice_s, slice_h, in_slice;
    logic               hold_full;
    logic [COL_W-1:0]   col;
    logic               eog;
    logic               avail, load_now, xfer;
    logic               load_shift, from_hold, hold_set, hold_clr, underrun_d;
    logic               pix_bit;
    logic               advance;

    assign rom_addr = char_code;
    assign in_slice = row_slice(rom_data, row_sel);

    // The shifter can take a new slice whenever it is idle or finishing the current cell.
    assign avail      = (state_q == IDLE) || eog;
    assign load_now   = hold_full && avail;
    assign char_ready = !hold_full || load_now;
    assign xfer       = char_valid && char_ready;
    assign advance    = (state_q == SHIFT) && pixel_en;
    assign busy       = (state_q == SHIFT) || hold_full;

    vgaconsole_pixel_counter #(
        .GAP_COLS (GAP_COLS),
        .SCALE_X  (SCALE_X)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (load_shift),
        .advance      (advance),
        .col          (col),
        .end_of_glyph (eog)
    );

    always_comb begin
        pix_bit = 1'b0;
        if (col < COL_W'(GLYPH_W)) begin
            pix_bit = slice_s[col];
        end
    end

    always_comb begin
        state_d    = state_q;
        load_shift = 1'b0;
        from_hold  = 1'b0;
        hold_set   = 1'b0;
        hold_clr   = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    load_shift = 1'b1;
                    from_hold  = 1'b1;
                    hold_clr   = 1'b1;
                    hold_set   = xfer;
                    state_d    = SHIFT;
                end else if (xfer) begin
                    load_shift = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (eog) begin
                    if (hold_full) begin
                        load_shift = 1'b1;
                        from_hold  = 1'b1;
                        hold_clr   = 1'b1;
                        hold_set   = xfer;
                    end else if (xfer) begin
                        load_shift = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    hold_set = xfer;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_s <= '0;
        end else if (load_shift) begin
            slice_s <= from_hold ? slice_h : in_slice;
        end
    end

    // A refill at end-of-glyph that also accepts a character keeps hold full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_h   <= '0;
            hold_full <= 1'b0;
        end else begin
            if (hold_set) begin
                slice_h <= in_slice;
            end
            if (hold_set) begin
                hold_full <= 1'b1;
            end else if (hold_clr) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= underrun_d;
            if (pixel_en) begin
                pixel_out <= (state_q == SHIFT) ? pix_bit : 1'b0;
            end
        end
    end

endmodule

// File: doc/vgaconsole_glyph_shifter.md
Name: vgaconsole_glyph_shifter

Overview:
- Reader side of the VGA console character ROM.
- Accepts a stream of character codes with a valid/ready handshake and drives the ROM address.
- Captures the 5-pixel slice for the current glyph row from the 35-bit bitmap and serializes it into a 1-bit pixel stream, advanced by a pixel-enable strobe from the VGA timing logic.
- Sits between the console text buffer reader and the VGA colour mux.

Parameters:
- GLYPH_W, 5, glyph width in pixels (bits per row slice).
- GLYPH_H, 7, glyph height in rows.
- GAP_COLS, 1, blank columns emitted after each glyph (0..3).
- SCALE_X, 1, horizontal repeat count per pixel (1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  char_code is valid.
- char_ready  out  1  block can accept a character this cycle.
- char_code  in  7  ASCII code, 32..127.
- row_sel  in  3  glyph row 0..GLYPH_H-1; sampled with the character.
- rom_addr  out  7  address to char ROM; combinational copy of char_code.
- rom_data  in  35  ROM bitmap, combinational response to rom_addr.
- pixel_en  in  1  advance one output pixel this cycle.
- pixel_out  out  1  current pixel, 1 = foreground.
- busy  out  1  shifter or hold register occupied.
- underrun  out  1  one-cycle pulse when a glyph ends with no character pending.

Behaviour:
- Bitmap layout: row r occupies rom_data[5r+4:5r]; bit 5r is the leftmost pixel; row 0 is the top row.
- row_sel > 6: the slice is forced to 5'b00000 (blank).
- Handshake: a transfer occurs when char_valid && char_ready on a rising clk edge. On a transfer the block latches row slice = rom_data[5*row_sel +: 5], sampled in the same cycle.
- char_ready = !hold_full || load_now, where load_now = the shifter consumes the hold register this cycle.
- Storage:
  - Hold register: slice_h[4:0], hold_full.
  - Shifter: slice_s[4:0], col counter 0..GLYPH_W+GAP_COLS-1, scale counter 0..SCALE_X-1, active flag.
- FSM states:
  - IDLE (active=0): pixel_out holds 0.
  - SHIFT (active=1): on each pixel_en, pixel_out <= (col < GLYPH_W) ? slice_s[col] : 0. Then the scale counter increments; on wrap, col increments.
  - END_OF_GLYPH: the pixel_en cycle with col = last and scale = last.
- Transitions:
  - IDLE -> SHIFT: hold_full, or a transfer in this cycle (bypass). The slice loads into the shifter with col=0, scale=0. The first pixel appears on the next pixel_en.
  - SHIFT -> SHIFT at END_OF_GLYPH with hold_full: load from hold, clear hold_full. If a transfer also occurs this cycle, the new slice goes into hold (hold stays full). Pixel stream is gapless.
  - SHIFT -> SHIFT at END_OF_GLYPH with hold empty and a transfer in this cycle: bypass loads the shifter directly.
  - SHIFT -> IDLE at END_OF_GLYPH with nothing available: assert underrun for 1 cycle; pixel_out returns to 0 on the next pixel_en.
- pixel_out is registered and changes only on pixel_en cycles or reset. Glyph length is (GLYPH_W+GAP_COLS)*SCALE_X pixel_en strobes.
- pixel_en low: counters and pixel_out hold, but transfers into hold still occur.
- busy = active || hold_full.
- Reset (asynchronous, any time, including mid-glyph):
  - pixel_out=0, underrun=0, busy=0, hold_full=0, active=0, counters=0, char_ready=1 after reset release.
  - A pending character is discarded.
- Codes < 32 pass through to rom_addr unchanged; the ROM defines their bitmap.

Decomposition:
- Package vgaconsole_pkg holds:
  - GLYPH_W, GLYPH_H, FONT_BITS (35), CODE_MIN (32), CODE_MAX (127).
  - enum typedef glyph_state_t {IDLE, SHIFT}.
  - Function row_slice(bitmap, row) returning 5 bits, blank for row > 6.
- One natural sub-module, vgaconsole_pixel_counter: the col/scale counter pair with an END_OF_GLYPH output. The rest stays in the top module.

Test Plan:
- Bench ROM maps code 65 with row 2 slice = 5'b10110; send 65, row_sel=2, then pixel_en every cycle -> pixel_out sequence is 0,1,1,0,1 then 0 (gap), then underrun pulses once, busy drops.
- SCALE_X=2, same character -> 0,0,1,1,1,1,0,0,1,1,0,0 over 12 strobes.
- Back-to-back codes 65 then 66 (row 0 slice 5'b11111), char_valid held high -> 12 contiguous pixels 0,1,1,0,1,0,1,1,1,1,1,0. No underrun between glyphs. char_ready deasserts only while hold is full and the shifter is mid-glyph.
- row_sel=7 with any code -> 5 zero pixels plus gap, handshake still completes.
- pixel_en gated 1-in-3 cycles -> same pixel sequence, each value stable for 3 cycles. Transfers still accepted while pixel_en is low.
- Assert rst_n low at pixel 3 of a glyph with hold full -> pixel_out, busy, underrun are 0 immediately (asynchronously). After release, char_ready=1 and the next character starts at col 0.
